// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter in front of a single data memory. Port 0 is the core LSU
// and port 1 is the loader/DMA. One transaction is in flight at a time:
// a request is granted and latched in IDLE, checked and issued in ISSUE,
// merged for byte/half stores in WRITE, and answered in RESP.
//
// Ports
//   clk, resetn            single clock, asynchronous active-low reset
//   mN_req_*               request channel of port N (valid/ready handshake,
//                          we, size, unsigned, addr, right-aligned wdata)
//   mN_rsp_*               response channel of port N (valid/ready handshake,
//                          formatted rdata, err)
//   mem_read_address       combinational read address (4 bytes, little-endian)
//   mem_read_data          combinational read result
//   mem_write_en/_address/_data  full-word write taken at the next clock edge
//   busy                   high whenever the arbiter is not idle
module dmem_arbiter #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_we,
  input  logic [1:0]  m0_req_size,
  input  logic        m0_req_unsigned,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_we,
  input  logic [1:0]  m1_req_size,
  input  logic        m1_req_unsigned,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,

  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched transaction
  logic        port;
  logic        last_grant;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] merge_q;

  // Arbitration
  logic        grant_port;
  logic        any_valid;
  logic        accept;

  // Selected request fields of the granted port
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // ISSUE-stage decode
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        access_err;
  logic        ext_bit;
  logic [31:0] load_fmt;
  logic [31:0] merged;

  // Round-robin: on a tie the port that did not win last time is chosen;
  // a lone requester always wins.
  always_comb begin
    any_valid  = m0_req_valid | m1_req_valid;
    grant_port = (m0_req_valid && m1_req_valid) ? ~last_grant : m1_req_valid;
  end

  always_comb begin
    if (grant_port) begin
      sel_we    = m1_req_we;
      sel_size  = m1_req_size;
      sel_uns   = m1_req_unsigned;
      sel_addr  = m1_req_addr;
      sel_wdata = m1_req_wdata;
    end else begin
      sel_we    = m0_req_we;
      sel_size  = m0_req_size;
      sel_uns   = m0_req_unsigned;
      sel_addr  = m0_req_addr;
      sel_wdata = m0_req_wdata;
    end
  end

  // Error check. The end address is formed one bit wider so an address near
  // 2^32 cannot wrap around and look in range.
  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    end_addr   = {1'b0, addr_q} + {30'd0, nbytes};
    access_err = (size_q == 2'b11)
              || ((size_q == 2'b01) && addr_q[0])
              || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
              || (end_addr > 33'(DEPTH_BYTES));
  end

  // Load formatting and read-modify-write merge
  always_comb begin
    ext_bit  = 1'b0;
    load_fmt = mem_read_data;
    case (size_q)
      2'b00: begin
        ext_bit  = ~uns_q & mem_read_data[7];
        load_fmt = {{24{ext_bit}}, mem_read_data[7:0]};
      end
      2'b01: begin
        ext_bit  = ~uns_q & mem_read_data[15];
        load_fmt = {{16{ext_bit}}, mem_read_data[15:0]};
      end
      default: load_fmt = mem_read_data;
    endcase
  end

  always_comb begin
    if (size_q == 2'b00) begin
      merged = {merge_q[31:8], wdata_q[7:0]};
    end else begin
      merged = {merge_q[31:16], wdata_q[15:0]};
    end
  end

  // Next state and memory-side outputs
  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    m0_req_ready      = 1'b0;
    m1_req_ready      = 1'b0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_en      = 1'b0;
    mem_write_data    = '0;

    case (state)
      IDLE: begin
        // ready is gated by resetn so it cannot rise while reset is held
        if (any_valid && resetn) begin
          accept       = 1'b1;
          m0_req_ready = ~grant_port;
          m1_req_ready = grant_port;
          state_next   = ISSUE;
        end
      end

      ISSUE: begin
        if (access_err) begin
          state_next = RESP;
        end else if (!we_q) begin
          mem_read_address = addr_q;
          state_next       = RESP;
        end else if (size_q == 2'b10) begin
          mem_write_en      = 1'b1;
          mem_write_address = addr_q;
          mem_write_data    = wdata_q;
          state_next        = RESP;
        end else begin
          mem_read_address = addr_q;
          state_next       = WRITE;
        end
      end

      WRITE: begin
        mem_write_en      = 1'b1;
        mem_write_address = addr_q;
        mem_write_data    = merged;
        state_next        = RESP;
      end

      RESP: begin
        if ((port == 1'b0 && m0_rsp_ready) || (port == 1'b1 && m1_rsp_ready)) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Response channels: only the granted port sees valid/data/err
  assign m0_rsp_valid = (state == RESP) && (port == 1'b0);
  assign m1_rsp_valid = (state == RESP) && (port == 1'b1);
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid & err_q;
  assign m1_rsp_err   = m1_rsp_valid & err_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      merge_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        port       <= grant_port;
        last_grant <= grant_port;
        we_q       <= sel_we;
        size_q     <= sel_size;
        uns_q      <= sel_uns;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
      end
      if (state == ISSUE) begin
        err_q   <= access_err;
        rdata_q <= (access_err || we_q) ? '0 : load_fmt;
        merge_q <= mem_read_data;
      end
    end
  end

endmodule
